// File: rtl/arm_ctrl_fsm_pkg.sv
// arm_ctrl_pkg: shared types and constants for the ARM32 multi-cycle control FSM.
//   state_e      - FSM state encoding
//   CNT_W        - latency counter width (covers MEM_LAT up to 15)
//   ALU_*        - ALU operation codes driven on ALU_op
//   OP_*         - special opcodes (NOP, HLT) and the CMP low nibble
//   FLAG_*       - NZCV bit positions inside the CPSR
//   dp_alu_op()  - data-processing opcode[2:0] to ALU operation
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd7;

  localparam int unsigned OP_NOP    = 0;
  localparam int unsigned OP_HLT    = 1;
  localparam logic [3:0]  OP_CMP_LO = 4'b0010;

  localparam int unsigned FLAG_N = 31;
  localparam int unsigned FLAG_Z = 30;
  localparam int unsigned FLAG_C = 29;
  localparam int unsigned FLAG_V = 28;

  function automatic logic [2:0] dp_alu_op(input logic [2:0] fn);
    logic [2:0] op;
    case (fn)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SUB;
      3'b010:  op = ALU_SUB;  // CMP subtracts, result only feeds the flags
      3'b011:  op = ALU_AND;
      3'b100:  op = ALU_ORR;
      3'b101:  op = ALU_XOR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/arm_ctrl_fsm_cond_eval.sv
// cond_eval: combinational ARM condition-field evaluator.
//   cond [3:0] - ARM condition field (EQ..AL, 1111 = never)
//   nzcv [3:0] - flags, N at bit 3 down to V at bit 0
//   pass       - high when the instruction should execute
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    pass = 1'b0;
    case (cond)
      4'h0: pass = z;                     // EQ
      4'h1: pass = ~z;                    // NE
      4'h2: pass = c;                     // CS
      4'h3: pass = ~c;                    // CC
      4'h4: pass = n;                     // MI
      4'h5: pass = ~n;                    // PL
      4'h6: pass = v;                     // VS
      4'h7: pass = ~v;                    // VC
      4'h8: pass = c & ~z;                // HI
      4'h9: pass = ~c | z;                // LS
      4'hA: pass = (n == v);              // GE
      4'hB: pass = (n != v);              // LT
      4'hC: pass = ~z & (n == v);         // GT
      4'hD: pass = z | (n != v);          // LE
      4'hE: pass = 1'b1;                  // AL
      default: pass = 1'b0;               // 1111 treated as never
    endcase
  end

endmodule

// File: rtl/arm_ctrl_fsm.sv
// arm_ctrl_fsm: multi-cycle control FSM for the ARM32 datapath.
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, HALT on HLT.
//   clk, rst (sync, active high), start
//   opcode, status_reg (CPSR, NZCV in [31:28]), cond
//   waiting                         - high in IDLE/HALT
//   wb_sel                          - 0 = ALU result, 1 = RAM data
//   sel_A, sel_B, sel_shift         - operand muxes
//   w_en, en_A, en_B, en_C, en_S    - register enables
//   status_w_en                     - CPSR flag write
//   ALU_op                          - ALU operation (zero-extended)
//   load_ir, load_pc, clear_pc      - IR/PC control
//   load_addr, sel_addr, ram_w_en   - address register, RAM address source, RAM write
// Outputs decode combinationally from state, counter, opcode and cond.
module arm_ctrl_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [31:0]         status_reg,
  input  logic [3:0]          cond,
  output logic                waiting,
  output logic [1:0]          wb_sel,
  output logic                sel_A,
  output logic                sel_B,
  output logic                sel_shift,
  output logic                w_en,
  output logic                en_A,
  output logic                en_B,
  output logic                en_C,
  output logic                en_S,
  output logic                status_w_en,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                load_ir,
  output logic                load_pc,
  output logic                clear_pc,
  output logic                load_addr,
  output logic                sel_addr,
  output logic                ram_w_en
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       cond_pass;
  logic       last_cnt;
  logic       is_nop, is_hlt, is_ls, is_load, is_cmp;
  logic [2:0] alu_op;
  logic       unused_status;

  assign unused_status = ^status_reg[27:0];

  cond_eval u_cond_eval (
    .cond (cond),
    .nzcv ({status_reg[FLAG_N], status_reg[FLAG_Z], status_reg[FLAG_C], status_reg[FLAG_V]}),
    .pass (cond_pass)
  );

  assign last_cnt = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign is_nop   = (opcode == OPCODE_W'(OP_NOP));
  assign is_hlt   = (opcode == OPCODE_W'(OP_HLT));
  assign is_ls    = opcode[6];
  assign is_load  = opcode[6] & opcode[5];
  assign is_cmp   = ~opcode[6] & (opcode[3:0] == OP_CMP_LO);

  // Load/store address arithmetic uses the U bit; data-processing uses the table.
  assign alu_op = is_ls ? (opcode[2] ? ALU_ADD : ALU_SUB) : dp_alu_op(opcode[2:0]);

  always_comb begin
    state_d     = state_q;
    waiting     = 1'b0;
    wb_sel      = '0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    sel_shift   = 1'b0;
    w_en        = 1'b0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_C        = 1'b0;
    en_S        = 1'b0;
    status_w_en = 1'b0;
    ALU_op      = '0;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    clear_pc    = 1'b0;
    load_addr   = 1'b0;
    sel_addr    = 1'b0;
    ram_w_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        waiting  = 1'b1;
        clear_pc = 1'b1;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (last_cnt) begin
          load_ir = 1'b1;
          load_pc = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_pass || is_nop) begin
          state_d = S_FETCH;
        end else if (is_hlt) begin
          state_d = S_HALT;
        end else begin
          en_A      = opcode[3];
          en_B      = opcode[4];
          en_S      = opcode[4];
          sel_shift = opcode[5];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        sel_A  = ~opcode[3];
        sel_B  = ~opcode[4];
        en_C   = 1'b1;
        ALU_op = ALU_OP_W'(alu_op);
        if (is_ls) begin
          load_addr = 1'b1;
          state_d   = S_MEM;
        end else begin
          status_w_en = is_cmp;
          state_d     = S_WB;
        end
      end
      S_MEM: begin
        sel_addr = 1'b1;
        ram_w_en = ~opcode[5];
        if (last_cnt) state_d = opcode[5] ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_en = ~is_cmp;
        if (is_load) begin
          wb_sel = 2'd1;
        end else begin
          // keep the ALU result stable while C is written back
          sel_A  = ~opcode[3];
          sel_B  = ~opcode[4];
          ALU_op = ALU_OP_W'(alu_op);
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        waiting = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change, so entry to FETCH/MEM sees zero.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// tb_arm_ctrl_fsm: scoreboard bench for arm_ctrl_fsm with MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
// Stimulus pushes the expected output word for each cycle; a negedge monitor pops and compares.
module tb_arm_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, start1, start3;
  logic [6:0]  opcode;
  logic [3:0]  cond;
  logic [31:0] status_reg;

  logic       waiting1, sel_A1, sel_B1, sel_shift1, w_en1, en_A1, en_B1, en_C1, en_S1, status_w_en1;
  logic       load_ir1, load_pc1, clear_pc1, load_addr1, sel_addr1, ram_w_en1;
  logic [1:0] wb_sel1;
  logic [2:0] ALU_op1;
  logic       waiting3, sel_A3, sel_B3, sel_shift3, w_en3, en_A3, en_B3, en_C3, en_S3, status_w_en3;
  logic       load_ir3, load_pc3, clear_pc3, load_addr3, sel_addr3, ram_w_en3;
  logic [1:0] wb_sel3;
  logic [2:0] ALU_op3;

  arm_ctrl_fsm #(.OPCODE_W(7), .ALU_OP_W(3), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .opcode(opcode), .status_reg(status_reg), .cond(cond),
    .waiting(waiting1), .wb_sel(wb_sel1), .sel_A(sel_A1), .sel_B(sel_B1), .sel_shift(sel_shift1),
    .w_en(w_en1), .en_A(en_A1), .en_B(en_B1), .en_C(en_C1), .en_S(en_S1), .status_w_en(status_w_en1),
    .ALU_op(ALU_op1), .load_ir(load_ir1), .load_pc(load_pc1), .clear_pc(clear_pc1),
    .load_addr(load_addr1), .sel_addr(sel_addr1), .ram_w_en(ram_w_en1)
  );

  arm_ctrl_fsm #(.OPCODE_W(7), .ALU_OP_W(3), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .opcode(opcode), .status_reg(status_reg), .cond(cond),
    .waiting(waiting3), .wb_sel(wb_sel3), .sel_A(sel_A3), .sel_B(sel_B3), .sel_shift(sel_shift3),
    .w_en(w_en3), .en_A(en_A3), .en_B(en_B3), .en_C(en_C3), .en_S(en_S3), .status_w_en(status_w_en3),
    .ALU_op(ALU_op3), .load_ir(load_ir3), .load_pc(load_pc3), .clear_pc(clear_pc3),
    .load_addr(load_addr3), .sel_addr(sel_addr3), .ram_w_en(ram_w_en3)
  );

  logic [20:0] act1, act3;
  assign act1 = {waiting1, wb_sel1, sel_A1, sel_B1, sel_shift1, w_en1, en_A1, en_B1, en_C1, en_S1,
                 status_w_en1, ALU_op1, load_ir1, load_pc1, clear_pc1, load_addr1, sel_addr1, ram_w_en1};
  assign act3 = {waiting3, wb_sel3, sel_A3, sel_B3, sel_shift3, w_en3, en_A3, en_B3, en_C3, en_S3,
                 status_w_en3, ALU_op3, load_ir3, load_pc3, clear_pc3, load_addr3, sel_addr3, ram_w_en3};

  localparam logic [20:0] M_WAIT    = 21'h100000;
  localparam logic [20:0] M_WB1     = 21'h040000;
  localparam logic [20:0] M_SELA    = 21'h020000;
  localparam logic [20:0] M_SELB    = 21'h010000;
  localparam logic [20:0] M_SHIFT   = 21'h008000;
  localparam logic [20:0] M_WEN     = 21'h004000;
  localparam logic [20:0] M_ENA     = 21'h002000;
  localparam logic [20:0] M_ENB     = 21'h001000;
  localparam logic [20:0] M_ENC     = 21'h000800;
  localparam logic [20:0] M_ENS     = 21'h000400;
  localparam logic [20:0] M_SWE     = 21'h000200;
  localparam logic [20:0] M_LIR     = 21'h000020;
  localparam logic [20:0] M_LPC     = 21'h000010;
  localparam logic [20:0] M_CLR     = 21'h000008;
  localparam logic [20:0] M_LADDR   = 21'h000004;
  localparam logic [20:0] M_SELADDR = 21'h000002;
  localparam logic [20:0] M_RAMW    = 21'h000001;
  localparam logic [20:0] M_NONE    = 21'h000000;

  localparam logic [6:0] OP_ADD = 7'b0011000;

  function automatic logic [20:0] alu(input logic [2:0] a);
    return {12'd0, a, 6'd0};
  endfunction

  logic [20:0] exp_q[$];
  string       nm_q[$];
  int          dut_q[$];
  int          tests  = 0;
  int          failed = 0;

  logic [20:0] mon_e, mon_a;
  string       mon_nm;
  int          mon_d;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      mon_d  = dut_q.pop_front();
      mon_a  = (mon_d == 1) ? act1 : act3;
      tests++;
      if (mon_a !== mon_e) begin
        failed++;
        $display("FAIL %s dut%0d: outputs got %h expected %h", mon_nm, mon_d, mon_a, mon_e);
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [20:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    dut_q.push_back(d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in the first FETCH cycle of an instruction; leaves in the cycle after it completes.
  task automatic run_instr(input string nm, input int d, input int lat, input logic [6:0] op,
                           input logic [3:0] cnd, input logic [31:0] st, input bit pass);
    logic [20:0] e, hold;
    logic [2:0]  a;
    opcode = op; cond = cnd; status_reg = st;
    if (d == 1) start1 = 1'b0; else start3 = 1'b0;
    for (int i = 0; i < lat; i++) begin
      chk({nm, "_fetch"}, d, (i == lat - 1) ? (M_LIR | M_LPC) : M_NONE);
      tick();
    end
    if (!pass || op == 7'd0 || op == 7'd1) begin
      chk({nm, "_dec_skip"}, d, M_NONE);
      tick();
      return;
    end
    e = M_NONE;
    if (op[3]) e = e | M_ENA;
    if (op[4]) e = e | M_ENB | M_ENS;
    if (op[5]) e = e | M_SHIFT;
    chk({nm, "_dec"}, d, e);
    tick();
    if (op[6]) a = op[2] ? 3'd0 : 3'd1;
    else begin
      case (op[2:0])
        3'd1, 3'd2: a = 3'd1;
        3'd3:       a = 3'd2;
        3'd4:       a = 3'd3;
        3'd5:       a = 3'd7;
        default:    a = 3'd0;
      endcase
    end
    hold = alu(a);
    if (!op[3]) hold = hold | M_SELA;
    if (!op[4]) hold = hold | M_SELB;
    e = hold | M_ENC;
    if (!op[6]) begin
      if (op[3:0] == 4'b0010) e = e | M_SWE;
      chk({nm, "_exec"}, d, e);
      tick();
      chk({nm, "_wb"}, d, (op[3:0] == 4'b0010) ? hold : (hold | M_WEN));
      tick();
    end else begin
      chk({nm, "_exec"}, d, e | M_LADDR);
      tick();
      for (int i = 0; i < lat; i++) begin
        chk({nm, "_mem"}, d, op[5] ? M_SELADDR : (M_SELADDR | M_RAMW));
        tick();
      end
      if (op[5]) begin
        chk({nm, "_wb"}, d, M_WEN | M_WB1);
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
    opcode = 7'd0; cond = 4'hE; status_reg = 32'd0;

    // dut1: reset, start, ADD
    tick();
    chk("rst_idle_a", 1, M_WAIT | M_CLR);
    tick();
    chk("rst_idle_b", 1, M_WAIT | M_CLR);
    rst1 = 1'b0; start1 = 1'b1;
    tick();
    run_instr("add",     1, 1, OP_ADD,     4'hE, 32'h0000_0000, 1'b1);
    run_instr("cmp",     1, 1, 7'b0010010, 4'hE, 32'h4000_0000, 1'b1);
    run_instr("ne_skip", 1, 1, OP_ADD,     4'h1, 32'h4000_0000, 1'b0);
    run_instr("eq_p",    1, 1, OP_ADD,     4'h0, 32'h4000_0000, 1'b1);
    run_instr("eq_f",    1, 1, OP_ADD,     4'h0, 32'h0000_0000, 1'b0);
    run_instr("cs_p",    1, 1, OP_ADD,     4'h2, 32'h2000_0000, 1'b1);
    run_instr("cc_f",    1, 1, OP_ADD,     4'h3, 32'h2000_0000, 1'b0);
    run_instr("vs_p",    1, 1, OP_ADD,     4'h6, 32'h1000_0000, 1'b1);
    run_instr("hi_f",    1, 1, OP_ADD,     4'h8, 32'h6000_0000, 1'b0);
    run_instr("ge_p",    1, 1, OP_ADD,     4'hA, 32'h9000_0000, 1'b1);
    run_instr("lt_p",    1, 1, OP_ADD,     4'hB, 32'h8000_0000, 1'b1);
    run_instr("gt_f",    1, 1, OP_ADD,     4'hC, 32'h1000_0000, 1'b0);
    run_instr("le_p",    1, 1, OP_ADD,     4'hD, 32'h4000_0000, 1'b1);
    run_instr("nv_f",    1, 1, OP_ADD,     4'hF, 32'hF000_0000, 1'b0);
    run_instr("xor",     1, 1, 7'b0000101, 4'hE, 32'h0000_0000, 1'b1);
    run_instr("orr_sh",  1, 1, 7'b0100100, 4'hE, 32'h0000_0000, 1'b1);
    run_instr("and",     1, 1, 7'b0001011, 4'hE, 32'h0000_0000, 1'b1);
    run_instr("op7_add", 1, 1, 7'b0000111, 4'hE, 32'h0000_0000, 1'b1);
    run_instr("nop",     1, 1, 7'b0000000, 4'hE, 32'h0000_0000, 1'b1);
    run_instr("hlt",     1, 1, 7'b0000001, 4'hE, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      start1 = i[0];
      chk("halt_hold", 1, M_WAIT);
      tick();
    end

    // dut3: load, interrupted store, DP, store
    chk("rst3_idle", 3, M_WAIT | M_CLR);
    rst3 = 1'b0; start3 = 1'b1;
    tick();
    run_instr("load3", 3, 3, 7'b1111100, 4'hE, 32'h0000_0000, 1'b1);
    opcode = 7'b1011000; cond = 4'hE;
    chk("st_fetch0", 3, M_NONE);               tick();
    chk("st_fetch1", 3, M_NONE);               tick();
    chk("st_fetch2", 3, M_LIR | M_LPC);        tick();
    chk("st_dec",    3, M_ENA | M_ENB | M_ENS); tick();
    chk("st_exec",   3, M_ENC | M_LADDR | alu(3'd1)); tick();
    chk("st_mem1",   3, M_SELADDR | M_RAMW);   tick();
    chk("st_mem2",   3, M_SELADDR | M_RAMW);
    rst3 = 1'b1;
    tick();
    chk("st_rst_idle", 3, M_WAIT | M_CLR);
    rst3 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("st_after_rst", 3, M_WAIT | M_CLR);
      tick();
    end
    start3 = 1'b1;
    chk("idle_start3", 3, M_WAIT | M_CLR);
    tick();
    run_instr("add3",   3, 3, OP_ADD,     4'hE, 32'h0000_0000, 1'b1);
    run_instr("store3", 3, 3, 7'b1011100, 4'hE, 32'h0000_0000, 1'b1);
    chk("final_fetch", 3, M_NONE);
    tick();

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/arm_ctrl_fsm.md
# arm_ctrl_fsm

Parametrised multi-cycle control FSM for the ARM32 datapath. It sequences fetch, operand load, execute, optional memory access and writeback, and evaluates the ARM condition field against the NZCV flags. It holds off RAM accesses for a configurable latency and halts on HLT. It drives the same enable/select strobes the datapath already consumes (regfile, A/B/shift/C registers, ALU, IR, PC, address register, RAM), and adds a status-flag write strobe and a memory-access path.

## Interface
- `OPCODE_W`, 7: decoded opcode width (minimum 7)
- `ALU_OP_W`, 3: ALU operation code width (minimum 3)
- `MEM_LAT`, 1: RAM read/write latency in cycles (1..15)
- `clk` in 1: sole clock; all state changes on its rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: leave IDLE and begin fetching
- `opcode` in `OPCODE_W`: decoded opcode of the current IR
- `status_reg` in 32: CPSR; N=[31], Z=[30], C=[29], V=[28]
- `cond` in 4: ARM condition field of the current IR
- `waiting` out 1: high in IDLE and HALT only
- `wb_sel` out 2: writeback source; 0 = ALU (C), 1 = RAM data
- `sel_A`, `sel_B`, `sel_shift` out 1 each: datapath operand muxes
- `w_en`, `en_A`, `en_B`, `en_C`, `en_S`, `status_w_en` out 1 each: register enables
- `ALU_op` out `ALU_OP_W`: ADD=0, SUB=1, AND=2, ORR=3, XOR=7, zero-extended
- `load_ir`, `load_pc`, `clear_pc` out 1 each: IR/PC control
- `load_addr`, `sel_addr`, `ram_w_en` out 1 each: address register load, RAM address source (0 = PC, 1 = address register), RAM write

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters IDLE.
- **Outputs:** Moore-style and purely combinational from state, a latency counter, and `opcode`/`cond`. Every output defaults to 0.
- **IDLE:** `clear_pc`=1 and `waiting`=1. Goes to FETCH when `start`=1.
- **FETCH:** `sel_addr`=0. The latency counter counts `MEM_LAT` cycles. In the final cycle, `load_ir`=1 and `load_pc`=1 (PC+4); then go to DECODE.
- **DECODE:**
  - Condition fail: go to FETCH. All strobes stay 0.
  - Condition pass: evaluate with the standard ARM table 0000..1110 (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL). `cond`=1111 is treated as never.
  - Special opcodes: `opcode`=0 (NOP) goes to FETCH. `opcode`=1 (HLT) goes to HALT.
  - Operand loads: `en_A`=`opcode[3]`; `en_B`=`en_S`=`opcode[4]`; `sel_shift`=`opcode[5]`.
  - Otherwise go to EXEC.
- **EXEC:**
  - Operand selects: `sel_A`=~`opcode[3]`, `sel_B`=~`opcode[4]`.
  - `ALU_op` maps from `opcode[2:0]`: 000 ADD, 001 SUB, 010 SUB (CMP), 011 AND, 100 ORR, 101 XOR, others ADD. `en_C`=1.
  - Data-processing (`opcode[6]`=0): go to WB. When `opcode[3:0]`=0010 (CMP), also set `status_w_en`=1.
  - Load/store (`opcode[6]`=1): `opcode[2]`=U selects ADD (1) or SUB (0). `load_addr`=1. Go to MEM.
- **MEM:**
  - `sel_addr`=1. The counter counts `MEM_LAT` cycles.
  - Store (`opcode[5]`=0): `ram_w_en`=1 in every MEM cycle, then go to FETCH.
  - Load (`opcode[5]`=1): go to WB.
- **WB:**
  - `w_en`=1 unless the opcode is CMP.
  - `wb_sel`=1 for a load, 0 otherwise. The ALU inputs/op from EXEC are held stable for a data-processing writeback.
  - Go to FETCH.
- **HALT:** `waiting`=1. Absorbing; only `rst` leaves it.

## Timing
- Cycles per instruction:
  - Data-processing: `MEM_LAT`+3.
  - Store: `MEM_LAT`+2+`MEM_LAT`.
  - Load: `MEM_LAT`+3+`MEM_LAT`.
  - Condition fail or NOP: `MEM_LAT`+1.
- **Latency counter:**
  - Width is ceil(log2(16)) = 4 bits.
  - Cleared on entry to FETCH and to MEM.
  - The final cycle is the one where counter = `MEM_LAT`−1.
- **Reset:** `rst` sampled high in any state, including mid-MEM with `ram_w_en` high, forces IDLE and clears the counter on the next edge. No write strobe is asserted in the reset cycle's successor.
- **Inputs:** `cond`/`status_reg` are sampled only in DECODE. Flag changes made by `status_w_en` take effect for the next instruction.
- **`start`:** ignored outside IDLE.

## Structure
- Package `arm_ctrl_pkg`: state enum, ALU op constants (ADD/SUB/AND/ORR/XOR), special opcodes (NOP, HLT, CMP low nibble), flag bit indices.
- Sub-module `cond_eval`: purely combinational. Inputs `cond` and NZCV; output `pass`.
- FSM, counter and output decode live in `arm_ctrl_fsm`.

## Test plan
- **Reset and start:** `rst`=1 for 2 cycles, then `start`=1. Required:
  - IDLE shows `waiting`=1 and `clear_pc`=1 with every other output 0.
  - The first FETCH appears one cycle after `start`.
- **ADD, `MEM_LAT`=1:** `opcode`=7'b0011000, `cond`=1110. Required:
  - `load_ir` in cycle 1.
  - `en_A`=`en_B`=`en_S`=1 in cycle 2.
  - `ALU_op`=0 with `en_C` in cycle 3.
  - `w_en`=1, `wb_sel`=0 in cycle 4; next state FETCH.
- **CMP then conditional:** CMP with Z set → `status_w_en`=1 and `w_en`=0. Next instruction with `cond`=0001 (NE) and Z=1 → skips after DECODE with no strobes, total 2 cycles.
- **Load, `MEM_LAT`=3:** `opcode`=7'b1111100. Required: FETCH 3 cycles, MEM 3 cycles with `sel_addr`=1, then WB with `w_en`=1 and `wb_sel`=1; 9 cycles total.
- **Store interrupted:** store with `MEM_LAT`=3, `rst` asserted in MEM cycle 2. Required: IDLE next cycle, `ram_w_en`=0 thereafter.
- **HLT:** `opcode`=1 → HALT with `waiting`=1 held for 20 cycles regardless of `start`.
